led_display_sched: RTL and testbench

Sequencer and arbiter for the single `led_driver` digit engine on the front-panel LED display. Three requesters compete for the display: account balance, payment amount, and status/error code. This block grants one of them round-robin, latches its value (saturated to the display width), and loads it into `led_driver`. It then steps `led_driver` through every digit with timed `next_num` pulses, holds the display for a fixed dwell, and re-arbitrates.

---
 rtl/led_display_sched.sv | 154 +++++++++++++++
 tb/tb_led_display_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/led_display_sched.sv
// led_display_sched
// Round-robin arbiter and sequencer for the single led_driver digit engine.
// Grants one of three requesters, latches its value clamped to the display
// range, loads it into led_driver, steps through every digit with timed
// drv_next pulses, dwells, then re-arbitrates.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   req        per-source request (0 balance, 1 payment, 2 status)
//   req_value  {value2, value1, value0}, 32-bit unsigned each
//   grant      one-hot pulse in the LOAD cycle
//   busy       high from LOAD until the IDLE cycle after done
//   disp_src   source currently on display
//   sat        latched value was clamped to 10^DIGITS-1
//   drv_rst    load/clear pulse to led_driver
//   drv_value  value presented to led_driver
//   drv_next   digit-advance pulse to led_driver
//   done       pulse on the last dwell cycle
module led_display_sched #(
  parameter int DIGITS      = 6,
  parameter int STEP_CYCLES = 4,
  parameter int HOLD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [95:0] req_value,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [1:0]  disp_src,
  output logic        sat,
  output logic        drv_rst,
  output logic [31:0] drv_value,
  output logic        drv_next,
  output logic        done
);

  // 10^n - 1 computed wide so DIGITS=10 does not wrap.
  function automatic logic [33:0] limit_f(input int n);
    logic [35:0] v;
    v = 36'd1;
    for (int i = 0; i < n; i++) v = v * 36'd10;
    return 34'(v - 36'd1);
  endfunction

  localparam logic [33:0] LIMIT = limit_f(DIGITS);
  localparam int DW   = $clog2(DIGITS + 1);
  localparam int CMAX = (STEP_CYCLES > HOLD_CYCLES) ? STEP_CYCLES : HOLD_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [2:0] {IDLE, LOAD, STEP, WAIT, HOLD} state_t;

  state_t          state_q;
  logic [1:0]      last_q;
  logic [DW-1:0]   dig_q;
  logic [CW-1:0]   cnt_q;

  // Round-robin winner: search upward from last_q+1, modulo 3.
  logic [1:0]  p0, p1, p2, win;
  logic [31:0] win_val;
  logic        win_sat;

  always_comb begin
    case (last_q)
      2'd0:    begin p0 = 2'd1; p1 = 2'd2; p2 = 2'd0; end
      2'd1:    begin p0 = 2'd2; p1 = 2'd0; p2 = 2'd1; end
      default: begin p0 = 2'd0; p1 = 2'd1; p2 = 2'd2; end
    endcase
    if (req[p0])      win = p0;
    else if (req[p1]) win = p1;
    else              win = p2;
    case (win)
      2'd0:    win_val = req_value[31:0];
      2'd1:    win_val = req_value[63:32];
      default: win_val = req_value[95:64];
    endcase
    win_sat = ({2'b00, win_val} > LIMIT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 2'd2;
      dig_q     <= '0;
      cnt_q     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      disp_src  <= '0;
      sat       <= 1'b0;
      drv_rst   <= 1'b0;
      drv_value <= '0;
      drv_next  <= 1'b0;
      done      <= 1'b0;
    end else begin
      // Pulse outputs default low; they are set on entry into their state.
      grant    <= '0;
      drv_rst  <= 1'b0;
      drv_next <= 1'b0;
      done     <= 1'b0;
      case (state_q)
        IDLE: begin
          busy <= 1'b0;
          if (|req) begin
            state_q   <= LOAD;
            last_q    <= win;
            grant     <= 3'b001 << win;
            drv_rst   <= 1'b1;
            busy      <= 1'b1;
            disp_src  <= win;
            sat       <= win_sat;
            drv_value <= win_sat ? LIMIT[31:0] : win_val;
          end
        end
        LOAD: begin
          // Digit counter counts the pulse being emitted in STEP.
          state_q  <= STEP;
          drv_next <= 1'b1;
          dig_q    <= DW'(1);
        end
        STEP: begin
          state_q <= WAIT;
          cnt_q   <= CW'(STEP_CYCLES - 2);
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (dig_q < DW'(DIGITS)) begin
              state_q  <= STEP;
              drv_next <= 1'b1;
              dig_q    <= dig_q + DW'(1);
            end else begin
              state_q <= HOLD;
              cnt_q   <= CW'(HOLD_CYCLES - 1);
              done    <= (HOLD_CYCLES == 1);
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        HOLD: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
            done  <= (cnt_q == CW'(1));
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_display_sched.sv
// Directed bench for led_display_sched with default parameters
// (DIGITS=6, STEP_CYCLES=4, HOLD_CYCLES=16). Cycle indices below are
// relative to the LOAD (grant) cycle, idx0; done lands at idx40 and the
// next IDLE cycle is idx41.
module tb_led_display_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [95:0] req_value;
  logic [2:0]  grant;
  logic        busy;
  logic [1:0]  disp_src;
  logic        sat;
  logic        drv_rst;
  logic [31:0] drv_value;
  logic        drv_next;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  led_display_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_value(req_value),
    .grant(grant), .busy(busy), .disp_src(disp_src), .sat(sat),
    .drv_rst(drv_rst), .drv_value(drv_value), .drv_next(drv_next),
    .done(done)
  );

  always #10 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [42:0] outs;
    repeat (3) @(negedge clk);
    outs = {grant, busy, disp_src, sat, drv_rst, drv_value, drv_next, done};
    n_chk++;
    if (outs !== 43'd0) begin
      n_fail++; $display("FAIL reset_hold: got %h expected 0", outs);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      outs = {grant, busy, disp_src, sat, drv_rst, drv_value, drv_next, done};
      n_chk++;
      if (outs !== 43'd0) begin
        n_fail++; $display("FAIL reset_idle cyc %0d: got %h expected 0", i, outs);
      end
    end
  endtask

  task automatic test_single();
    logic exp_next, exp_done, exp_busy;
    req_value[31:0] = 32'd123456;
    req = 3'b001;
    @(negedge clk);  // idx0 = LOAD
    n_chk++;
    if ({grant, drv_rst, busy, sat, disp_src} !== {3'b001, 1'b1, 1'b1, 1'b0, 2'd0}) begin
      n_fail++; $display("FAIL single_load: got g=%b r=%b b=%b s=%b d=%0d expected g=001 r=1 b=1 s=0 d=0",
                         grant, drv_rst, busy, sat, disp_src);
    end
    n_chk++;
    if (drv_value !== 32'd123456) begin
      n_fail++; $display("FAIL single_value: got %0d expected 123456", drv_value);
    end
    req = 3'b000;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      exp_next = (i <= 21) && ((i - 1) % 4 == 0);
      exp_done = (i == 40);
      exp_busy = (i <= 40);
      n_chk++;
      if ({grant, drv_rst, drv_next, done, busy} !== {3'b000, 1'b0, exp_next, exp_done, exp_busy}) begin
        n_fail++;
        $display("FAIL single_seq idx%0d: got g=%b r=%b n=%b d=%b b=%b expected g=000 r=0 n=%b d=%b b=%b",
                 i, grant, drv_rst, drv_next, done, busy, exp_next, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_saturation();
    logic [31:0] vals [3];
    logic        sats [3];
    vals = '{32'd1000000, 32'd999999, 32'hFFFFFFFF};
    sats = '{1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 3; k++) begin
      req_value[63:32] = vals[k];
      req = 3'b010;
      @(negedge clk);
      n_chk++;
      if ({grant, disp_src, sat} !== {3'b010, 2'd1, sats[k]}) begin
        n_fail++; $display("FAIL sat_load %0d: got g=%b d=%0d s=%b expected g=010 d=1 s=%b",
                           k, grant, disp_src, sat, sats[k]);
      end
      n_chk++;
      if (drv_value !== 32'd999999) begin
        n_fail++; $display("FAIL sat_value %0d: got %0d expected 999999", k, drv_value);
      end
      req = 3'b000;
      repeat (41) @(negedge clk);
      // Latched value and flag persist through IDLE.
      n_chk++;
      if ({busy, sat, drv_value} !== {1'b0, sats[k], 32'd999999}) begin
        n_fail++; $display("FAIL sat_persist %0d: got b=%b s=%b v=%0d expected b=0 s=%b v=999999",
                           k, busy, sat, drv_value, sats[k]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  w;
    logic [31:0] ev;
    do_reset();
    req_value = {32'd33, 32'd22, 32'd11};
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      w = 2'(n % 3);
      ev = 32'(11 * (n % 3 + 1));
      @(negedge clk);  // LOAD
      n_chk++;
      if ({grant, disp_src, drv_value} !== {3'b001 << w, w, ev}) begin
        n_fail++; $display("FAIL rr_grant %0d: got g=%b d=%0d v=%0d expected g=%b d=%0d v=%0d",
                           n, grant, disp_src, drv_value, 3'b001 << w, w, ev);
      end
      req[w] = 1'b0;
      @(negedge clk);
      req[w] = 1'b1;
      repeat (40) @(negedge clk);  // idx41, IDLE
    end
    req = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_no_preempt();
    do_reset();
    req_value = {32'd42, 32'd0, 32'd7};
    req = 3'b001;
    @(negedge clk);
    n_chk++;
    if ({grant, drv_value} !== {3'b001, 32'd7}) begin
      n_fail++; $display("FAIL np_first: got g=%b v=%0d expected g=001 v=7", grant, drv_value);
    end
    req = 3'b000;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      n_chk++;
      if ({grant, done} !== {3'b000, (i == 40)}) begin
        n_fail++; $display("FAIL np_hold idx%0d: got g=%b d=%b expected g=000 d=%b",
                           i, grant, done, (i == 40));
      end
      if (i == 30) req = 3'b100;  // arrives during HOLD
    end
    @(negedge clk);  // idx42: two cycles after done
    n_chk++;
    if ({grant, disp_src, drv_value} !== {3'b100, 2'd2, 32'd42}) begin
      n_fail++; $display("FAIL np_grant: got g=%b d=%0d v=%0d expected g=100 d=2 v=42",
                         grant, disp_src, drv_value);
    end
    req = 3'b000;
    repeat (41) @(negedge clk);
  endtask

  task automatic test_reset_mid_step();
    logic [42:0] outs;
    int npulse;
    int ndone;
    do_reset();
    req_value = {32'd0, 32'd555, 32'd0};
    req = 3'b010;
    @(negedge clk);
    n_chk++;
    if (grant !== 3'b010) begin
      n_fail++; $display("FAIL rst_step_first: got g=%b expected g=010", grant);
    end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) begin
        n_chk++;
        if (drv_next !== 1'b1) begin
          n_fail++; $display("FAIL rst_step_third: got n=%b expected n=1", drv_next);
        end
      end
    end
    #2 rst = 1'b0;
    #1;
    outs = {grant, busy, disp_src, sat, drv_rst, drv_value, drv_next, done};
    n_chk++;
    if (outs !== 43'd0) begin
      n_fail++; $display("FAIL rst_step_async: got %h expected 0", outs);
    end
    repeat (2) @(negedge clk);
    outs = {grant, busy, disp_src, sat, drv_rst, drv_value, drv_next, done};
    n_chk++;
    if (outs !== 43'd0) begin
      n_fail++; $display("FAIL rst_step_held: got %h expected 0", outs);
    end
    rst = 1'b1;
    @(negedge clk);  // IDLE sampled the held req -> LOAD
    n_chk++;
    if ({grant, disp_src, drv_value, drv_rst} !== {3'b010, 2'd1, 32'd555, 1'b1}) begin
      n_fail++; $display("FAIL rst_step_regrant: got g=%b d=%0d v=%0d r=%b expected g=010 d=1 v=555 r=1",
                         grant, disp_src, drv_value, drv_rst);
    end
    req = 3'b000;
    npulse = 0;
    ndone  = 0;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (drv_next === 1'b1) npulse++;
      if (done === 1'b1) ndone++;
    end
    n_chk++;
    if (npulse != 6) begin
      n_fail++; $display("FAIL rst_step_pulses: got %0d expected 6", npulse);
    end
    n_chk++;
    if ({ndone[7:0], busy} !== {8'd1, 1'b0}) begin
      n_fail++; $display("FAIL rst_step_done: got done_cnt=%0d b=%b expected done_cnt=1 b=0", ndone, busy);
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 3'b000;
    req_value = '0;
    #5 rst = 1'b0;
    test_reset();
    test_single();
    test_saturation();
    test_round_robin();
    test_no_preempt();
    test_reset_mid_step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
